// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the core controller and muldiv_unit.
//   start  : request pulse, sampled only while the unit is idle
//   op     : RV32M funct3 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)
//   a, b   : rs1 / rs2 operands
//   busy   : operation in flight
//   done   : one-cycle completion pulse
//   result : result, held until the next accepted start
// Modports: master = controller side, slave = muldiv_unit side.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Operand magnitudes go through a shared one-bit-per-cycle shift-add / restoring-subtract
// datapath for WIDTH cycles, followed by a sign-fixup cycle. Divide-by-zero and signed
// overflow bypass the iteration and finish two cycles after start.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state and outputs
//   bus   : muldiv_unit_if.slave (start, op, a, b in; busy, done, result out)
// Build option: define MULDIV_FAST_MUL_EN to compute the four multiplies with a single-cycle
// 2*WIDTH product (done two cycles after start); divide timing is unchanged. Results are
// identical in both builds.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned     CntW   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic               special_q, special_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // Request decode
    logic             accept;
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_res;

    // A start coinciding with done is dropped; the controller re-issues it.
    assign accept   = bus.start & ~busy_q & ~done_q;
    assign a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                      (bus.op == 3'b100) || (bus.op == 3'b110);
    assign b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    assign a_neg    = a_signed & bus.a[WIDTH-1];
    assign b_neg    = b_signed & bus.b[WIDTH-1];
    // MinNeg negates to itself, which is its correct unsigned magnitude.
    assign a_mag    = a_neg ? -bus.a : bus.a;
    assign b_mag    = b_neg ? -bus.b : bus.b;
    assign div_zero = bus.op[2] && (bus.b == '0);
    assign div_ovf  = bus.op[2] && !bus.op[0] && (bus.a == MinNeg) && (bus.b == '1);
    assign special_res = div_zero ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : bus.a);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

    // Shared iteration step. Multiply: acc = {partial product, multiplier}, opnd = multiplicand.
    // Divide: acc = {remainder, quotient}, opnd = divisor; the adder runs as base - divisor.
    logic [WIDTH:0]     add_base, add_opnd, add_sum;
    logic               add_cin;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        if (op_q[2]) begin
            add_base = acc_q[2*WIDTH-1:WIDTH-1];  // remainder shifted left with next dividend bit
            add_opnd = ~{1'b0, opnd_q};
            add_cin  = 1'b1;
        end else begin
            add_base = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            add_opnd = acc_q[0] ? {1'b0, opnd_q} : '0;
            add_cin  = 1'b0;
        end
        add_sum = add_base + add_opnd + {{WIDTH{1'b0}}, add_cin};

        if (!op_q[2]) begin
            acc_step = {add_sum, acc_q[WIDTH-1:1]};
        end else if (!add_sum[WIDTH]) begin
            acc_step = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
        end
    end

    // Sign fixup and result selection
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem, fix_res;

    always_comb begin
        prod = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quot = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000:                 fix_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = quot;
            default:                fix_res = rem;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        special_d = special_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = bus.op;
                    a_neg_d   = a_neg;
                    b_neg_d   = b_neg;
                    special_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StCalc;
                    if (bus.op[2]) begin
                        opnd_d = b_mag;
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                    end
`ifdef MULDIV_FAST_MUL_EN
                    if (!bus.op[2]) begin
                        acc_d   = fast_prod;
                        state_d = StFix;
                    end
`endif
                    if (div_zero || div_ovf) begin
                        special_d = 1'b1;
                        acc_d     = {{WIDTH{1'b0}}, special_res};
                        state_d   = StFix;
                    end
                end
            end
            StCalc: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = special_q ? acc_q[WIDTH-1:0] : fix_res;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            special_q <= 1'b0;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            op_q      <= op_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            special_q <= special_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at WIDTH=32. The driver pushes the expected
// result and completion cycle for every accepted request; a monitor pops and compares on done.
module tb_muldiv_unit;
    localparam int unsigned W = 32;
    localparam logic [W-1:0] Min = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int unsigned  cyc;
        string        name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: plain 64-bit arithmetic from the RV32M definitions.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: begin
                if (b == '0) return op[1] ? a : '1;
                if (!op[0] && a == Min && b == '1) return op[1] ? '0 : a;
                if (!op[0]) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end
                p = op[1] ? r : q;
                return p[31:0];
            end
        endcase
    endfunction

    // Edges from the accepting edge to the edge that raises done.
    function automatic int unsigned lat(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        if (op[2] && (b == '0 || (!op[0] && a == Min && b == '1))) return 1;
        return W + 1;
    endfunction

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Issue one request and wait for done. A nonzero intrude_at drives a conflicting start
    // for one cycle that many cycles into the operation; it must be ignored.
    task automatic issue(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int intrude_at);
        int   guard;
        bit   busy_ok;
        exp_t e;
        wait_idle();
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.res  = model(op, a, b);
        e.cyc  = cyc + lat(op, a, b);
        e.name = name;
        sb_q.push_back(e);
        busy_ok = 1'b1;
        guard   = 0;
        @(negedge clk);
        while (!bus.done && guard < 200) begin
            if (!bus.busy) busy_ok = 1'b0;
            guard++;
            if (guard == intrude_at) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.a     = ~a;
                bus.b     = b + 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            n_total++;
            $display("FAIL %s_timeout: done not seen within 200 cycles, expected after %0d",
                     name, lat(op, a, b));
            if (sb_q.size() > 0) void'(sb_q.pop_back());
        end
        check({name, "_busy_held"}, 64'(busy_ok), 64'd1);
    endtask

    // Monitor: compare every done against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_done: done high with nothing outstanding, result 0x%0h",
                         bus.result);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_result"}, 64'(bus.result), 64'(mon_e.res));
                check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return Min;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom());
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_result", 64'(bus.result), 64'd0);
        reset = 1'b0;

        issue("mul_neg",     3'd0, 32'd7,        32'hFFFF_FFFD, 0);
        issue("mulh_min",    3'd1, Min,          Min,           0);
        issue("mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue("mulhsu_m1",   3'd2, 32'hFFFF_FFFF, 32'd2,        0);
        issue("div_neg",     3'd4, 32'hFFFF_FFF9, 32'd2,        0);
        issue("rem_neg",     3'd6, 32'hFFFF_FFF9, 32'd2,        0);
        issue("divu",        3'd5, 32'hFFFF_FFF9, 32'd2,        0);
        issue("remu",        3'd7, 32'hFFFF_FFF9, 32'd2,        0);
        issue("divu_zero",   3'd5, 32'd5,        32'd0,         0);
        issue("remu_zero",   3'd7, 32'd5,        32'd0,         0);
        issue("div_zero",    3'd4, Min,          32'd0,         0);
        issue("div_ovf",     3'd4, Min,          32'hFFFF_FFFF, 0);
        issue("rem_ovf",     3'd6, Min,          32'hFFFF_FFFF, 0);
        issue("div_intrude", 3'd4, 32'd1000,     32'd7,         5);

        // Reset in the middle of an iterative operation.
        wait_idle();
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 32'd123;
        bus.b     = 32'd456;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_busy", 64'(bus.busy), 64'd0);
        check("midreset_done", 64'(bus.done), 64'd0);
        check("midreset_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        issue("mul_after_reset", 3'd0, 32'd3, 32'd4, 0);

        for (int i = 0; i < 200; i++) begin
            issue($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick(), pick(), 0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the multicycle RISC-V core, implementing the full RV32M operation set (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) at a parametrised data width. It sits beside the ALU. The controller issues an operation with a start pulse and stalls on busy until done. Operand magnitudes are processed one bit per cycle by a shared shift-add / restoring-subtract datapath, followed by a sign-fixup step.

## Interface
- WIDTH, 32, operand/result width; even, ≥ 4
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only when busy=0
- op  in  3  funct3 encoding: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- a  in  WIDTH  rs1 operand (multiplicand / dividend)
- b  in  WIDTH  rs2 operand (multiplier / divisor)
- busy  out  1  operation in flight; start ignored
- done  out  1  one-cycle pulse; result valid from this cycle
- result  out  WIDTH  held until the next accepted start

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - Latch op, a and b.
  - Record operand signs: a is signed for mulh, mulhsu, div and rem; b is signed for mulh, div and rem.
  - Load operand magnitudes and clear the counter.
  - Go to CALC, except for special cases, which go directly to FIX.
- CALC, multiply: each cycle, if multiplier LSB=1, add the multiplicand into the upper half of a 2·WIDTH accumulator, then shift right by 1.
- CALC, divide: each cycle, shift the remainder:quotient pair left by 1 and trial-subtract the divisor. If non-negative, keep the difference and set the quotient LSB.
- CALC runs exactly WIDTH cycles, then goes to FIX.
- FIX:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the operand signs differ.
  - Give the remainder the sign of the dividend.
  - Select the result: low half (mul), high half (mulh*), quotient or remainder.
  - Assert done and go to IDLE.
- Special cases, detected in IDLE from the operands:
  - b=0: div/divu → all ones; rem/remu → a.
  - Signed overflow, div/rem with a=100…0 and b=all ones: div → a; rem → 0.
- busy=1 in CALC and FIX, and also in the cycle after start is accepted.
- start while busy: ignored, with no effect on the running operation.
- start in the same cycle as done: ignored. The controller must re-issue it in the next cycle.
- Reset, asynchronous, at any point including mid-operation:
  - State goes to IDLE.
  - busy=0, done=0, result=0.
  - Accumulator and counter cleared.

## Timing
- Start sampled at edge E.
- Normal op: done=1 during the cycle after edge E+WIDTH+1, i.e. WIDTH+2 cycles from start (34 at WIDTH=32).
- Special case: done 2 cycles after start.
- done is high for exactly one cycle.
- result changes only on the edge that raises done. The next start may be accepted in the cycle after done.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- MULDIV_FAST_MUL_EN, defined:
  - The four multiply ops use a single-cycle 2·WIDTH signed/unsigned product computed in IDLE.
  - The FSM goes IDLE → FIX; done arrives 2 cycles after start.
  - Divide timing is unchanged.
- MULDIV_FAST_MUL_EN, undefined:
  - Multiplies use the iterative path with WIDTH+2 latency.
  - No hardware multiplier is inferred.
- Results are bit-identical in both builds.

## Test plan
All cases at WIDTH=32.
- mul a=7, b=0xFFFFFFFD (−3) → result 0xFFFFFFEB.
  - done exactly 34 cycles after start (2 with MULDIV_FAST_MUL_EN).
  - busy high throughout.
- High-half multiplies:
  - mulh 0x80000000×0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- Divides:
  - div 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - rem same operands → 0xFFFFFFFF.
  - divu 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - remu same operands → 1.
- Divide by zero, done 2 cycles after start:
  - divu 5/0 → 0xFFFFFFFF.
  - remu 5/0 → 5.
  - div 0x80000000/0 → 0xFFFFFFFF.
- Signed overflow, done 2 cycles after start:
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - rem same operands → 0.
- Control:
  - A second start with different operands at cycle 5 of a running div is ignored; the first result is correct.
  - reset asserted mid-CALC → busy, done and result read 0 immediately.
  - After reset releases, mul 3×4 → 12 with nominal latency.
